multi_wave_gen: RTL
===================

MULTI_WAVE_GEN -- requirements
Module: multi_wave_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent channels (1..16).
REQ-002 SHALL have parameter PHASE_W, default 32, phase accumulator width in bits.
REQ-003 SHALL have parameter BURST_W, default 16, burst-length counter width.
REQ-004 SHALL have parameter real AMPLITUDE, default 2.5, full-scale peak amplitude in volts.
REQ-005 SHALL have parameter real OFFSET, default 2.5, DC offset in volts.
REQ-006 SHALL have port clk, input, 1, sample clock.
REQ-007 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-008 SHALL have port sample_en, input, 1, global sample strobe.
REQ-009 SHALL have port start, input, NUM_CH, per-channel start pulse.
REQ-010 SHALL have port stop, input, NUM_CH, per-channel stop pulse.
REQ-011 SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-012 SHALL have port cfg_ch, input, 4, target channel.
REQ-013 SHALL have port cfg_sel, input, 2, target register: 0 phase_inc, 1 mode, 2 amp_code, 3 burst_len.
REQ-014 SHALL have port cfg_data, input, max(PHASE_W,BURST_W), write data, LSB-aligned.
REQ-015 SHALL have port wave_out, output, real[NUM_CH], per-channel sample.
REQ-016 SHALL have port out_valid, output, NUM_CH, one-cycle strobe marking a new wave_out sample.
REQ-017 SHALL have port busy, output, NUM_CH, channel is in RUN.

Function
REQ-018 Each channel SHALL run a two-state FSM, IDLE and RUN: start in IDLE -> RUN with acc cleared to 0 and burst count cleared to 0; stop in RUN -> IDLE.
REQ-019 If start and stop are asserted in the same cycle, stop SHALL win; start while in RUN SHALL be ignored.
REQ-020 In RUN with sample_en=1, the channel SHALL register wave_out from the current acc, pulse out_valid, and update acc <= acc + phase_inc modulo 2^PHASE_W (wrap silently); sample latency is one cycle from the strobe.
REQ-021 The phase fraction p SHALL be acc/2^PHASE_W in [0,1); the amplitude A SHALL be AMPLITUDE*amp_code/255.
REQ-022 Mode 0 (sine) SHALL output OFFSET + A*sin(2*pi*p), using the DPI-C pure import dpi_sin.
REQ-023 Mode 1 (square) SHALL output OFFSET+A for p<0.5, else OFFSET-A.
REQ-024 Mode 2 (triangle) SHALL output OFFSET + A*(4p-1) for p<0.5, else OFFSET + A*(3-4p).
REQ-025 Mode 3 (sawtooth) SHALL output OFFSET + A*(2p-1).
REQ-026 With burst_len=0 the channel SHALL run continuously; otherwise, after the burst_len-th sample, it SHALL return to IDLE in the same cycle that sample's out_valid is pulsed.
REQ-027 In IDLE, wave_out SHALL be held at OFFSET, with out_valid=0 and busy=0.
REQ-028 A configuration write SHALL take effect at the next clock edge and SHALL NOT reset acc or the burst count; a write to a running channel SHALL affect the next sample only.
REQ-029 A write with cfg_ch >= NUM_CH SHALL be ignored.
REQ-030 With sample_en=0, the channel SHALL hold acc, the burst count, and wave_out, with out_valid=0.

Reset
REQ-031 Asserting rst_n low SHALL immediately set all channels to IDLE, acc=0, burst count=0, wave_out=OFFSET, out_valid=0, and busy=0.
REQ-032 Reset SHALL set the configuration registers to phase_inc=0, mode=0, amp_code=255, and burst_len=0; reset mid-burst SHALL abort without a further out_valid.

Configuration
REQ-033 When macro MULTI_WAVE_GEN_NOISE_EN is defined, each channel SHALL add uniform noise of +/-AMPLITUDE/256 to each sample, using a per-channel 16-bit Galois LFSR (taps 0xB400, seed 0xACE1+ch) that advances on each out_valid.
REQ-034 When MULTI_WAVE_GEN_NOISE_EN is undefined, output SHALL be noise-free and no LFSR logic SHALL exist.

Structure
REQ-035 Package wave_gen_pkg SHALL hold wave_mode_e (SINE, SQUARE, TRIANGLE, SAW), cfg_sel_e, ch_state_e, PI/TWO_PI, and the dpi_sin import.
REQ-036 A sub-module wave_channel SHALL implement one channel (FSM, accumulator, waveform, optional noise), instantiated NUM_CH times by generate; the top SHALL decode configuration writes.

Verification
REQ-037 Sine test: ch0 phase_inc=2^PHASE_W/100, mode 0, amp_code 255, start, sample_en=1 -> the first sample is 2.5, the 26th sample is 5.0 (+/-1e-9), and the period is 100 samples.
REQ-038 Burst test: ch1 burst_len=5, mode 1, phase_inc=2^(PHASE_W-1) -> exactly 5 out_valid pulses alternating 5.0/0.0, then busy=0 and wave_out=2.5.
REQ-039 Collision test: start[2] and stop[2] in the same cycle while IDLE -> the channel stays IDLE; in RUN, stop -> busy=0 on the next cycle.
REQ-040 Wrap test: acc near 2^PHASE_W-1 with phase_inc=2 -> acc wraps to 0 or 1, and the sawtooth drops from ~5.0 to ~0.0.
REQ-041 Reset test: assert rst_n low mid-burst at an arbitrary time -> all outputs take reset values asynchronously, and the configuration reads back as defaults after reset.
REQ-042 Gating and invalid-write test: sample_en low for 10 cycles -> acc and wave_out are frozen; cfg_ch=NUM_CH -> no channel changes.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types, constants and waveform math for the multi-channel wave generator.
// The sine primitive dpi_sin is implemented natively in SystemVerilog with the
// expected name and signature, so the build needs no foreign code.
package wave_gen_pkg;

   typedef enum logic [1:0] {
      SINE     = 2'd0,
      SQUARE   = 2'd1,
      TRIANGLE = 2'd2,
      SAW      = 2'd3
   } wave_mode_e;

   typedef enum logic [1:0] {
      SEL_PHASE_INC = 2'd0,
      SEL_MODE      = 2'd1,
      SEL_AMP_CODE  = 2'd2,
      SEL_BURST_LEN = 2'd3
   } cfg_sel_e;

   typedef enum logic [0:0] {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   localparam real PI     = 3.14159265358979323846;
   localparam real TWO_PI = 2.0 * PI;

   localparam logic [7:0] AMP_CODE_FULL = 8'd255;

   // Range-reduce to [-pi, pi] and sum the Taylor series; 12 terms reach
   // double precision over that interval.
   function automatic real dpi_sin(input real x);
      real r;
      real term;
      real sum;
      r    = x - TWO_PI * $floor(x / TWO_PI + 0.5);
      term = r;
      sum  = r;
      for (int k = 1; k <= 12; k++) begin
         term = -term * r * r / real'((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

   // Map a phase fraction p in [0,1) to a sample for the selected shape.
   function automatic real wave_shape(input wave_mode_e mode, input real p,
                                      input real amp, input real offset);
      real y;
      case (mode)
         SINE:     y = offset + amp * dpi_sin(TWO_PI * p);
         SQUARE:   y = (p < 0.5) ? (offset + amp) : (offset - amp);
         TRIANGLE: y = (p < 0.5) ? (offset + amp * (4.0 * p - 1.0))
                                 : (offset + amp * (3.0 - 4.0 * p));
         default:  y = offset + amp * (2.0 * p - 1.0);
      endcase
      return y;
   endfunction

endpackage

// File: rtl/wave_channel.sv
// One generator channel: IDLE/RUN FSM, phase accumulator, burst counter,
// configuration registers and waveform shaping. When MULTI_WAVE_GEN_NOISE_EN is
// defined a 16-bit Galois LFSR adds +/-AMPLITUDE/256 uniform noise per sample.
module wave_channel
  import wave_gen_pkg::*;
#(
  parameter int  PHASE_W   = 32,
  parameter int  BURST_W   = 16,
`ifdef MULTI_WAVE_GEN_NOISE_EN
  parameter int  CH_IDX    = 0,
`endif
  parameter real AMPLITUDE = 2.5,
  parameter real OFFSET    = 2.5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic               start,
  input  logic               stop,
  input  logic               we_phase_inc,
  input  logic               we_mode,
  input  logic               we_amp_code,
  input  logic               we_burst_len,
  input  logic [PHASE_W-1:0] wr_phase_inc,
  input  logic [1:0]         wr_mode,
  input  logic [7:0]         wr_amp_code,
  input  logic [BURST_W-1:0] wr_burst_len,
  output real                wave_out,
  output logic               out_valid,
  output logic               busy
);

  localparam logic [0:0] ST_IDLE = 1'(CH_IDLE);
  localparam logic [0:0] ST_RUN  = 1'(CH_RUN);

  logic [0:0]         state;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] phase_inc;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_len;
  logic [BURST_W-1:0] burst_next;
  logic [1:0]         mode;
  logic [7:0]         amp_code;
  logic               take_sample;
  logic               burst_done;
  real                phase_frac;
  real                amp_val;
  real                noise;
  real                sample_val;

`ifdef MULTI_WAVE_GEN_NOISE_EN
  logic [15:0] lfsr;

  // Galois LFSR steps once per emitted sample; each channel has its own seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1 + 16'(CH_IDX);
    end else if (take_sample) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Scale the LFSR state to a symmetric +/-AMPLITUDE/256 offset.
  always_comb begin
    noise = (real'(lfsr) / 65535.0 * 2.0 - 1.0) * AMPLITUDE / 256.0;
  end
`else
  // Noise-free build.
  always_comb begin
    noise = 0.0;
  end
`endif

  // Next-sample value and burst bookkeeping derived from the current state.
  always_comb begin
    take_sample = (state == ST_RUN) && sample_en && !stop;
    burst_next  = burst_cnt + BURST_W'(1);
    burst_done  = (burst_len != '0) && (burst_next == burst_len);
    phase_frac  = real'(acc) / (2.0 ** PHASE_W);
    amp_val     = AMPLITUDE * real'(amp_code) / 255.0;
    sample_val  = wave_shape(wave_mode_e'(mode), phase_frac, amp_val, OFFSET) + noise;
  end

  // Configuration registers; writes never disturb the accumulator or burst count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_inc <= '0;
      mode      <= 2'(SINE);
      amp_code  <= AMP_CODE_FULL;
      burst_len <= '0;
    end else begin
      if (we_phase_inc) phase_inc <= wr_phase_inc;
      if (we_mode)      mode      <= wr_mode;
      if (we_amp_code)  amp_code  <= wr_amp_code;
      if (we_burst_len) burst_len <= wr_burst_len;
    end
  end

  // Channel FSM: stop beats start, start is ignored while running, and the
  // final burst sample drops back to IDLE in the same cycle it is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      burst_cnt <= '0;
      wave_out  <= OFFSET;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == ST_IDLE) begin
        wave_out <= OFFSET;
        if (start && !stop) begin
          state     <= ST_RUN;
          acc       <= '0;
          burst_cnt <= '0;
        end
      end else if (stop) begin
        state    <= ST_IDLE;
        wave_out <= OFFSET;
      end else if (take_sample) begin
        wave_out  <= sample_val;
        out_valid <= 1'b1;
        acc       <= acc + phase_inc;
        burst_cnt <= burst_next;
        if (burst_done) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-channel DDS waveform generator top: decodes configuration writes to
// the addressed channel and instantiates NUM_CH independent channels.
// Optional feature macro: MULTI_WAVE_GEN_NOISE_EN (per-channel LFSR noise).
module multi_wave_gen
  import wave_gen_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  PHASE_W   = 32,
  parameter int  BURST_W   = 16,
  parameter real AMPLITUDE = 2.5,
  parameter real OFFSET    = 2.5
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             sample_en,
  input  logic [NUM_CH-1:0]                                start,
  input  logic [NUM_CH-1:0]                                stop,
  input  logic                                             cfg_we,
  input  logic [3:0]                                       cfg_ch,
  input  logic [1:0]                                       cfg_sel,
  input  logic [((PHASE_W > BURST_W) ? PHASE_W : BURST_W)-1:0] cfg_data,
  output real                                              wave_out [NUM_CH],
  output logic [NUM_CH-1:0]                                out_valid,
  output logic [NUM_CH-1:0]                                busy
);

  cfg_sel_e sel;

  assign sel = cfg_sel_e'(cfg_sel);

  // Channels beyond NUM_CH never match, so writes addressed to them are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_hit;

    assign ch_hit = cfg_we && ({1'b0, cfg_ch} == 5'(i));

    wave_channel #(
      .PHASE_W   (PHASE_W),
      .BURST_W   (BURST_W),
`ifdef MULTI_WAVE_GEN_NOISE_EN
      .CH_IDX    (i),
`endif
      .AMPLITUDE (AMPLITUDE),
      .OFFSET    (OFFSET)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_en    (sample_en),
      .start        (start[i]),
      .stop         (stop[i]),
      .we_phase_inc (ch_hit && (sel == SEL_PHASE_INC)),
      .we_mode      (ch_hit && (sel == SEL_MODE)),
      .we_amp_code  (ch_hit && (sel == SEL_AMP_CODE)),
      .we_burst_len (ch_hit && (sel == SEL_BURST_LEN)),
      .wr_phase_inc (cfg_data[PHASE_W-1:0]),
      .wr_mode      (cfg_data[1:0]),
      .wr_amp_code  (cfg_data[7:0]),
      .wr_burst_len (cfg_data[BURST_W-1:0]),
      .wave_out     (wave_out[i]),
      .out_valid    (out_valid[i]),
      .busy         (busy[i])
    );
  end

endmodule
